// File: rtl/noc_cfg_pkg.sv
// Shared constants and types for the NoC configuration-register arbiter:
// register map, FSM states, requester identifiers and STATUS field layout.
package noc_cfg_pkg;

    localparam int unsigned ADDR_ID      = 0;
    localparam int unsigned ADDR_CTRL    = 1;
    localparam int unsigned ADDR_STATUS  = 2;
    localparam int unsigned ADDR_SCRATCH = 3;

    localparam int unsigned STAT_TXN_LSB = 0;
    localparam int unsigned STAT_TXN_W   = 16;
    localparam int unsigned STAT_ERR_LSB = 16;
    localparam int unsigned STAT_ERR_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        SIDE_A = 1'b0,
        SIDE_B = 1'b1
    } side_e;

    function automatic logic [STAT_ERR_W-1:0] sat_inc(input logic [STAT_ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/noc_cfg_arbiter_rr_arb2.sv
// Two-input round-robin selector; purely combinational, the priority pointer
// is owned by the instantiating module.
module rr_arb2
    import noc_cfg_pkg::*;
(
    input  logic [1:0] req_i,    // bit 0 = A, bit 1 = B
    input  side_e      ptr_i,
    output side_e      owner_o,
    output logic       valid_o
);

    // NOTE: every output gets a default before any branch so no path infers a latch.
    always_comb begin
        valid_o = |req_i;
        owner_o = ptr_i;
        if (req_i == 2'b01) begin
            owner_o = SIDE_A;
        end else if (req_i == 2'b10) begin
            owner_o = SIDE_B;
        end
    end

endmodule

// File: rtl/noc_cfg_arbiter.sv
// Configuration-register controller: round-robin arbitration between two requesters
// for one register bank (ID, CTRL, STATUS, SCRATCH), one transaction at a time.
module noc_cfg_arbiter
    import noc_cfg_pkg::*;
#(
    parameter int unsigned         SIZE_REG = 32,
    parameter logic [SIZE_REG-1:0] ID       = SIZE_REG'(32'h0000_1000),
    parameter int unsigned         ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_a,
    input  logic                we_a,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [SIZE_REG-1:0] wdata_a,
    input  logic                req_b,
    input  logic                we_b,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [SIZE_REG-1:0] wdata_b,
    output logic                gnt_a,
    output logic                gnt_b,
    output logic                rvalid_a,
    output logic                rvalid_b,
    output logic [SIZE_REG-1:0] rdata_a,
    output logic [SIZE_REG-1:0] rdata_b,
    output logic                err_a,
    output logic                err_b,
    output logic [SIZE_REG-1:0] ctrl_o
);

    state_e                  state_q, state_d;
    side_e                   ptr_q, ptr_d;
    side_e                   owner_q, owner_d;
    logic [SIZE_REG-1:0]     ctrl_q, ctrl_d;
    logic [SIZE_REG-1:0]     scratch_q, scratch_d;
    logic [STAT_TXN_W-1:0]   stat_txn_q, stat_txn_d;
    logic [STAT_ERR_W-1:0]   stat_err_q, stat_err_d;
    logic                    gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic                    rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic                    err_a_q, err_a_d, err_b_q, err_b_d;
    logic [SIZE_REG-1:0]     rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;

    side_e                   arb_owner;
    logic                    arb_valid;

    rr_arb2 u_rr_arb2 (
        .req_i   ({req_b, req_a}),
        .ptr_i   (ptr_q),
        .owner_o (arb_owner),
        .valid_o (arb_valid)
    );

    // The owner's request fields stay stable until its grant has been consumed.
    logic                    acc_we;
    logic [ADDR_W-1:0]       acc_addr;
    logic [SIZE_REG-1:0]     acc_wdata;
    assign acc_we    = (owner_q == SIDE_B) ? we_b    : we_a;
    assign acc_addr  = (owner_q == SIDE_B) ? addr_b  : addr_a;
    assign acc_wdata = (owner_q == SIDE_B) ? wdata_b : wdata_a;

    logic [SIZE_REG-1:0]     status_val;
    always_comb begin
        status_val = '0;
        status_val[STAT_TXN_LSB +: STAT_TXN_W] = stat_txn_q;
        status_val[STAT_ERR_LSB +: STAT_ERR_W] = stat_err_q;
    end

    logic [SIZE_REG-1:0]     acc_rdata;
    logic                    acc_err;
    logic                    wr_ctrl;
    logic                    wr_scratch;

    always_comb begin
        acc_rdata  = '0;
        acc_err    = 1'b0;
        wr_ctrl    = 1'b0;
        wr_scratch = 1'b0;
        if (acc_addr == ADDR_W'(ADDR_ID)) begin
            if (acc_we) acc_err   = 1'b1;
            else        acc_rdata = ID;
        end else if (acc_addr == ADDR_W'(ADDR_CTRL)) begin
            if (acc_we) wr_ctrl   = 1'b1;
            else        acc_rdata = ctrl_q;
        end else if (acc_addr == ADDR_W'(ADDR_STATUS)) begin
            if (acc_we) acc_err   = 1'b1;
            else        acc_rdata = status_val;
        end else if (acc_addr == ADDR_W'(ADDR_SCRATCH)) begin
            if (acc_we) wr_scratch = 1'b1;
            else        acc_rdata  = scratch_q;
        end else begin
            acc_err = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        ctrl_d     = ctrl_q;
        scratch_d  = scratch_q;
        stat_txn_d = stat_txn_q;
        stat_err_d = stat_err_q;
        gnt_a_d    = 1'b0;
        gnt_b_d    = 1'b0;
        rvalid_a_d = 1'b0;
        rvalid_b_d = 1'b0;
        err_a_d    = 1'b0;
        err_b_d    = 1'b0;
        rdata_a_d  = '0;
        rdata_b_d  = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    owner_d = arb_owner;
                    ptr_d   = (arb_owner == SIDE_A) ? SIDE_B : SIDE_A;
                    gnt_a_d = (arb_owner == SIDE_A);
                    gnt_b_d = (arb_owner == SIDE_B);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (wr_ctrl)    ctrl_d    = acc_wdata;
                if (wr_scratch) scratch_d = acc_wdata;
                stat_txn_d = stat_txn_q + 1'b1;
                if (acc_err) stat_err_d = sat_inc(stat_err_q);
                if (owner_q == SIDE_A) begin
                    rvalid_a_d = 1'b1;
                    rdata_a_d  = acc_rdata;
                    err_a_d    = acc_err;
                end else begin
                    rvalid_b_d = 1'b1;
                    rdata_b_d  = acc_rdata;
                    err_b_d    = acc_err;
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= SIDE_A;
            owner_q    <= SIDE_A;
            ctrl_q     <= '0;
            scratch_q  <= '0;
            stat_txn_q <= '0;
            stat_err_q <= '0;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            err_a_q    <= 1'b0;
            err_b_q    <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            ctrl_q     <= ctrl_d;
            scratch_q  <= scratch_d;
            stat_txn_q <= stat_txn_d;
            stat_err_q <= stat_err_d;
            gnt_a_q    <= gnt_a_d;
            gnt_b_q    <= gnt_b_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            err_a_q    <= err_a_d;
            err_b_q    <= err_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    assign gnt_a    = gnt_a_q;
    assign gnt_b    = gnt_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign err_a    = err_a_q;
    assign err_b    = err_b_q;
    assign ctrl_o   = ctrl_q;

endmodule

// File: tb/tb_noc_cfg_arbiter.sv
// Self-checking bench for noc_cfg_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a transaction-level model.
module tb_noc_cfg_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [3:0]  addr_a = '0, addr_b = '0;
    logic [31:0] wdata_a = '0, wdata_b = '0;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b;
    logic [31:0] rdata_a, rdata_b, ctrl_o;

    noc_cfg_arbiter #(.SIZE_REG(32), .ID(32'h0000_1000), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .err_a(err_a), .err_b(err_b),
        .ctrl_o(ctrl_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] ctrl_at_gnt;

    typedef struct {
        bit          ra, rb;
        bit          we_a;
        logic [3:0]  addr_a;
        logic [31:0] wd_a;
        bit          we_b;
        logic [3:0]  addr_b;
        logic [31:0] wd_b;
        bit          first_b;
        logic [31:0] rd0;
        bit          er0;
        logic [31:0] rd1;
        bit          er1;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Waits for a grant, checks owner and latency, then checks the response cycle.
    task automatic serve(input bit exp_b, input logic [31:0] exp_rd, input bit exp_er, input int exp_lat);
        int lat = 0;
        bit got = 0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (gnt_a || gnt_b) got = 1;
        end
        check("gnt_latency", 64'(lat), 64'(exp_lat));
        check("gnt_owner", {gnt_b, gnt_a}, exp_b ? 2'b10 : 2'b01);
        ctrl_at_gnt = ctrl_o;
        @(negedge clk);
        check("rvalid_owner", {rvalid_b, rvalid_a}, exp_b ? 2'b10 : 2'b01);
        if (exp_b) begin
            check("rdata_b", rdata_b, exp_rd);
            check("err_b", err_b, exp_er);
            check("idle_side_a", {rdata_a, err_a}, 0);
            req_b = 1'b0;
        end else begin
            check("rdata_a", rdata_a, exp_rd);
            check("err_a", err_a, exp_er);
            check("idle_side_b", {rdata_b, err_b}, 0);
            req_a = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        we_a = v.we_a; addr_a = v.addr_a; wdata_a = v.wd_a;
        we_b = v.we_b; addr_b = v.addr_b; wdata_b = v.wd_b;
        req_a = v.ra;  req_b = v.rb;
        serve(v.first_b, v.rd0, v.er0, 1);
        if (v.ra && v.rb) serve(!v.first_b, v.rd1, v.er1, 2);
    endtask

    task automatic lone(input bit b, input bit we, input logic [3:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_er);
        vec_t v;
        v = '{!b, b, we, addr, wd, we, addr, wd, b, exp_rd, exp_er, 32'h0, 1'b0};
        run_vec(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Transaction-level reference model of the register bank and arbiter.
    logic [31:0] m_ctrl, m_scratch;
    int          m_txn, m_errs;
    bit          m_ptr_b;

    task automatic model_reset();
        m_ctrl = 0; m_scratch = 0; m_txn = 0; m_errs = 0; m_ptr_b = 0;
    endtask

    task automatic model_access(input bit we, input logic [3:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output bit er);
        rd = 0;
        er = 0;
        case (addr)
            4'd0: if (we) er = 1; else rd = 32'h0000_1000;
            4'd1: if (we) m_ctrl = wd; else rd = m_ctrl;
            4'd2: if (we) er = 1; else rd = (32'(m_errs) << 16) | 32'(m_txn);
            4'd3: if (we) m_scratch = wd; else rd = m_scratch;
            default: er = 1;
        endcase
        m_txn = (m_txn + 1) % 65536;
        if (er && m_errs < 255) m_errs++;
    endtask

    task automatic model_fill(inout vec_t v);
        v.first_b = (v.ra && v.rb) ? m_ptr_b : v.rb;
        if (v.first_b) model_access(v.we_b, v.addr_b, v.wd_b, v.rd0, v.er0);
        else           model_access(v.we_a, v.addr_a, v.wd_a, v.rd0, v.er0);
        m_ptr_b = !v.first_b;
        v.rd1 = 0;
        v.er1 = 0;
        if (v.ra && v.rb) begin
            if (v.first_b) model_access(v.we_a, v.addr_a, v.wd_a, v.rd1, v.er1);
            else           model_access(v.we_b, v.addr_b, v.wd_b, v.rd1, v.er1);
            m_ptr_b = v.first_b;
        end
    endtask

    function automatic logic [3:0] rand_addr();
        int r = $urandom_range(0, 5);
        return (r < 4) ? 4'(r) : 4'($urandom_range(4, 15));
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[13];
        // ra rb  weA addrA wdA          weB addrB wdB          1stB rd0           er0 rd1           er1
        tbl[0]  = '{1, 1, 0, 4'd0,  32'h0,        0, 4'd3,  32'h0,        0, 32'h0000_1000, 0, 32'h0,         0};
        tbl[1]  = '{1, 0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,        0, 32'h0000_1000, 0, 32'h0,         0};
        tbl[2]  = '{1, 1, 0, 4'd1,  32'h0,        1, 4'd1,  32'hDEAD_BEEF, 1, 32'h0,         0, 32'hDEAD_BEEF, 0};
        tbl[3]  = '{0, 1, 0, 4'd0,  32'h0,        0, 4'd1,  32'h0,        1, 32'hDEAD_BEEF, 0, 32'h0,         0};
        tbl[4]  = '{1, 0, 1, 4'd0,  32'h1234_5678, 0, 4'd0, 32'h0,        0, 32'h0,         1, 32'h0,         0};
        tbl[5]  = '{1, 0, 0, 4'd0,  32'h0,        0, 4'd0,  32'h0,        0, 32'h0000_1000, 0, 32'h0,         0};
        tbl[6]  = '{1, 0, 0, 4'd7,  32'h0,        0, 4'd0,  32'h0,        0, 32'h0,         1, 32'h0,         0};
        tbl[7]  = '{0, 1, 0, 4'd0,  32'h0,        0, 4'd2,  32'h0,        1, 32'h0002_0009, 0, 32'h0,         0};
        tbl[8]  = '{1, 1, 1, 4'd3,  32'hA5A5_0001, 1, 4'd2, 32'h5,        0, 32'h0,         0, 32'h0,         1};
        tbl[9]  = '{0, 1, 0, 4'd0,  32'h0,        0, 4'd3,  32'h0,        1, 32'hA5A5_0001, 0, 32'h0,         0};
        tbl[10] = '{0, 1, 0, 4'd0,  32'h0,        1, 4'd15, 32'hFFFF_FFFF, 1, 32'h0,         1, 32'h0,         0};
        tbl[11] = '{1, 0, 0, 4'd2,  32'h0,        0, 4'd0,  32'h0,        0, 32'h0004_000E, 0, 32'h0,         0};
        tbl[12] = '{1, 1, 0, 4'd1,  32'h0,        0, 4'd1,  32'h0,        1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0};

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_handshake", {gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b}, 0);
        check("rst_rdata", {rdata_a, rdata_b}, 0);
        check("rst_ctrl_o", ctrl_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(tbl[i]);

        // CTRL write becomes visible on ctrl_o only after the GRANT cycle.
        lone(1, 1, 4'd1, 32'h0BAD_F00D, 32'h0, 0);
        check("ctrl_o_during_grant", ctrl_at_gnt, 32'hDEAD_BEEF);
        check("ctrl_o_after_grant", ctrl_o, 32'h0BAD_F00D);
        lone(1, 0, 4'd1, 32'h0, 32'h0BAD_F00D, 0);

        // Transaction counter wrap: 19 transactions so far, 4 errors.
        @(negedge clk);
        force dut.stat_txn_q = 16'hFFFF;
        @(negedge clk);
        release dut.stat_txn_q;
        lone(0, 0, 4'd2, 32'h0, 32'h0004_FFFF, 0);
        lone(0, 0, 4'd2, 32'h0, 32'h0004_0000, 0);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) lone(0, 0, 4'd7, 32'h0, 32'h0, 1);
        lone(0, 0, 4'd2, 32'h0, 32'h00FF_012D, 0);

        // Reset during RESP of a SCRATCH write.
        @(negedge clk);
        we_a = 1'b1; addr_a = 4'd3; wdata_a = 32'hCAFE_0000; req_a = 1'b1;
        @(negedge clk);
        check("mid_rst_gnt", gnt_a, 1'b1);
        @(negedge clk);
        check("mid_rst_rvalid_before", rvalid_a, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_rvalid_after", {rvalid_a, rvalid_b, gnt_a, gnt_b, err_a, err_b}, 0);
        check("mid_rst_rdata_after", rdata_a, 0);
        req_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        lone(0, 0, 4'd3, 32'h0, 32'h0, 0);
        check("mid_rst_ctrl_o", ctrl_o, 0);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 200; i++) begin
            vec_t v;
            int sel = $urandom_range(0, 2);
            v.ra = (sel != 1);
            v.rb = (sel != 0);
            v.we_a = 1'($urandom_range(0, 1)); v.addr_a = rand_addr(); v.wd_a = $urandom;
            v.we_b = 1'($urandom_range(0, 1)); v.addr_b = rand_addr(); v.wd_b = $urandom;
            model_fill(v);
            run_vec(v);
            check("rand_ctrl_o", ctrl_o, m_ctrl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
